// File: rtl/serial2tcp_loopback_fifo.sv
// serial2tcp_loopback_fifo: ready/valid loopback FIFO that transforms words on write and counts transfers
module serial2tcp_loopback_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int MODE = 0,
  parameter logic [DATA_WIDTH-1:0] XOR_MASK = '1
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    flush,
  input  logic                    serial2tcp_sink_valid,
  output logic                    serial2tcp_sink_ready,
  input  logic [DATA_WIDTH-1:0]   serial2tcp_sink_data,
  output logic                    serial2tcp_source_valid,
  input  logic                    serial2tcp_source_ready,
  output logic [DATA_WIDTH-1:0]   serial2tcp_source_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic [31:0]             rx_count,
  output logic [31:0]             tx_count
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  logic [DATA_WIDTH-1:0] xf;
  // Handshakes from registered state only; a flushed edge neither pushes nor pops
  always_comb begin
    serial2tcp_sink_ready = (level != (AW+1)'(DEPTH)) && !flush && !sys_rst;
    serial2tcp_source_valid = (level != '0) && !sys_rst;
    serial2tcp_source_data = mem[rd_ptr];
    push = serial2tcp_sink_valid && serial2tcp_sink_ready;
    pop = serial2tcp_source_valid && serial2tcp_source_ready && !flush;
    xf = MODE == 1 ? serial2tcp_sink_data ^ XOR_MASK :
         MODE == 2 ? serial2tcp_sink_data + DATA_WIDTH'(1) : serial2tcp_sink_data;
  end
  // Storage holds already-transformed words and needs no reset
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= xf;
  end
  // Pointers, occupancy and transfer counters
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      rx_count <= '0;
      tx_count <= '0;
    end else begin
      if (push) rx_count <= rx_count + 32'd1;
      if (pop) tx_count <= tx_count + 32'd1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level <= '0;
      end else begin
        wr_ptr <= wr_ptr + AW'(push);
        rd_ptr <= rd_ptr + AW'(pop);
        level <= level + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end
endmodule

// File: tb/tb_serial2tcp_loopback_fifo.sv
// tb_serial2tcp_loopback_fifo: directed scenarios over pass-through, XOR, increment and depth-4 instances
module tb_serial2tcp_loopback_fifo;
  logic clk = 0, rst = 1, flush = 0, sv = 0, srd = 0;
  logic [7:0] sd = 0;
  logic rdy [4];
  logic vld [4];
  logic [7:0] dat [4];
  logic [31:0] rx [4];
  logic [31:0] tx [4];
  logic [4:0] lvl0, lvl1, lvl2;
  logic [2:0] lvl3;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  serial2tcp_loopback_fifo #(.DATA_WIDTH(8), .DEPTH(16), .MODE(0)) u0 (.sys_clk(clk), .sys_rst(rst), .flush(flush),
    .serial2tcp_sink_valid(sv), .serial2tcp_sink_ready(rdy[0]), .serial2tcp_sink_data(sd),
    .serial2tcp_source_valid(vld[0]), .serial2tcp_source_ready(srd), .serial2tcp_source_data(dat[0]),
    .level(lvl0), .rx_count(rx[0]), .tx_count(tx[0]));
  serial2tcp_loopback_fifo #(.DATA_WIDTH(8), .DEPTH(16), .MODE(1), .XOR_MASK(8'hFF)) u1 (.sys_clk(clk), .sys_rst(rst), .flush(flush),
    .serial2tcp_sink_valid(sv), .serial2tcp_sink_ready(rdy[1]), .serial2tcp_sink_data(sd),
    .serial2tcp_source_valid(vld[1]), .serial2tcp_source_ready(srd), .serial2tcp_source_data(dat[1]),
    .level(lvl1), .rx_count(rx[1]), .tx_count(tx[1]));
  serial2tcp_loopback_fifo #(.DATA_WIDTH(8), .DEPTH(16), .MODE(2)) u2 (.sys_clk(clk), .sys_rst(rst), .flush(flush),
    .serial2tcp_sink_valid(sv), .serial2tcp_sink_ready(rdy[2]), .serial2tcp_sink_data(sd),
    .serial2tcp_source_valid(vld[2]), .serial2tcp_source_ready(srd), .serial2tcp_source_data(dat[2]),
    .level(lvl2), .rx_count(rx[2]), .tx_count(tx[2]));
  serial2tcp_loopback_fifo #(.DATA_WIDTH(8), .DEPTH(4), .MODE(0)) u3 (.sys_clk(clk), .sys_rst(rst), .flush(flush),
    .serial2tcp_sink_valid(sv), .serial2tcp_sink_ready(rdy[3]), .serial2tcp_sink_data(sd),
    .serial2tcp_source_valid(vld[3]), .serial2tcp_source_ready(srd), .serial2tcp_source_data(dat[3]),
    .level(lvl3), .rx_count(rx[3]), .tx_count(tx[3]));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1; sv = 0; srd = 0; flush = 0;
    step;
    rst = 0;
  endtask

  task automatic test_reset;
    rst = 1; sv = 1; sd = 8'h11;
    step; step;
    checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", rdy[0]); end
    checks++; if (vld[0] !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", vld[0]); end
    checks++; if (lvl0 !== 5'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", lvl0); end
    checks++; if (rx[0] !== 32'd0 || tx[0] !== 32'd0) begin errors++; $display("FAIL rst_counts got rx=%0d tx=%0d exp 0/0", rx[0], tx[0]); end
    sv = 0; rst = 0; #1;
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b exp 1", rdy[0]); end
    checks++; if (vld[0] !== 1'b0) begin errors++; $display("FAIL post_rst_valid got %b exp 0", vld[0]); end
  endtask

  task automatic test_stream;
    do_reset;
    srd = 1;
    for (int i = 0; i < 16; i++) begin
      sv = 1; sd = 8'(i);
      step;
      checks++; if (vld[0] !== 1'b1 || dat[0] !== 8'(i)) begin errors++; $display("FAIL stream_data[%0d] got v=%b d=%h exp v=1 d=%h", i, vld[0], dat[0], 8'(i)); end
      checks++; if (lvl0 !== 5'd1) begin errors++; $display("FAIL stream_level[%0d] got %0d exp 1", i, lvl0); end
    end
    sv = 0;
    step;
    checks++; if (lvl0 !== 5'd0 || vld[0] !== 1'b0) begin errors++; $display("FAIL stream_drain got lvl=%0d v=%b exp 0/0", lvl0, vld[0]); end
    checks++; if (rx[0] !== 32'd16 || tx[0] !== 32'd16) begin errors++; $display("FAIL stream_counts got rx=%0d tx=%0d exp 16/16", rx[0], tx[0]); end
  endtask

  task automatic test_full;
    do_reset;
    for (int i = 0; i < 17; i++) begin
      sv = 1; sd = 8'(i); #1;
      checks++; if (rdy[0] !== (i < 16)) begin errors++; $display("FAIL full_ready[%0d] got %b exp %b", i, rdy[0], i < 16); end
      step;
    end
    checks++; if (lvl0 !== 5'd16) begin errors++; $display("FAIL full_level got %0d exp 16", lvl0); end
    srd = 1; sv = 1; sd = 8'hEE; #1;
    checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL full_pop_ready got %b exp 0", rdy[0]); end
    step;
    sv = 0; srd = 0; #1;
    checks++; if (lvl0 !== 5'd15) begin errors++; $display("FAIL full_pop_level got %0d exp 15", lvl0); end
    checks++; if (rx[0] !== 32'd16 || tx[0] !== 32'd1) begin errors++; $display("FAIL full_pop_counts got rx=%0d tx=%0d exp 16/1", rx[0], tx[0]); end
    checks++; if (dat[0] !== 8'h01 || rdy[0] !== 1'b1) begin errors++; $display("FAIL full_pop_head got d=%h r=%b exp 01/1", dat[0], rdy[0]); end
    do_reset;
    for (int i = 0; i < 5; i++) begin
      sv = 1; sd = 8'(i); #1;
      checks++; if (rdy[3] !== (i < 4)) begin errors++; $display("FAIL d4_ready[%0d] got %b exp %b", i, rdy[3], i < 4); end
      step;
    end
    sv = 0;
    checks++; if (lvl3 !== 3'd4) begin errors++; $display("FAIL d4_level got %0d exp 4", lvl3); end
  endtask

  task automatic test_transform;
    do_reset;
    srd = 1; sv = 1;
    sd = 8'h5A; step;
    checks++; if (dat[1] !== 8'hA5) begin errors++; $display("FAIL xor_5a got %h exp a5", dat[1]); end
    checks++; if (dat[0] !== 8'h5A) begin errors++; $display("FAIL pass_5a got %h exp 5a", dat[0]); end
    checks++; if (dat[2] !== 8'h5B) begin errors++; $display("FAIL inc_5a got %h exp 5b", dat[2]); end
    sd = 8'h00; step;
    checks++; if (dat[1] !== 8'hFF) begin errors++; $display("FAIL xor_00 got %h exp ff", dat[1]); end
    sd = 8'hFF; step;
    checks++; if (dat[2] !== 8'h00 || vld[2] !== 1'b1) begin errors++; $display("FAIL inc_ff got d=%h v=%b exp 00/1", dat[2], vld[2]); end
    sd = 8'h7F; step;
    checks++; if (dat[2] !== 8'h80) begin errors++; $display("FAIL inc_7f got %h exp 80", dat[2]); end
    sv = 0; step;
    checks++; if (tx[2] !== 32'd4 || lvl2 !== 5'd0) begin errors++; $display("FAIL inc_drain got tx=%0d lvl=%0d exp 4/0", tx[2], lvl2); end
  endtask

  task automatic test_flush;
    do_reset;
    for (int i = 0; i < 5; i++) begin sv = 1; sd = 8'(8'h20 + i); step; end
    checks++; if (lvl0 !== 5'd5) begin errors++; $display("FAIL flush_pre_level got %0d exp 5", lvl0); end
    flush = 1; srd = 1; sv = 1; sd = 8'h99; #1;
    checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", rdy[0]); end
    step;
    flush = 0; sv = 0; #1;
    checks++; if (lvl0 !== 5'd0 || vld[0] !== 1'b0) begin errors++; $display("FAIL flush_state got lvl=%0d v=%b exp 0/0", lvl0, vld[0]); end
    checks++; if (rx[0] !== 32'd5 || tx[0] !== 32'd0) begin errors++; $display("FAIL flush_counts got rx=%0d tx=%0d exp 5/0", rx[0], tx[0]); end
    sv = 1; sd = 8'h33; step;
    sv = 0;
    checks++; if (vld[0] !== 1'b1 || dat[0] !== 8'h33) begin errors++; $display("FAIL flush_next got v=%b d=%h exp 1/33", vld[0], dat[0]); end
    step;
    checks++; if (tx[0] !== 32'd1 || rx[0] !== 32'd6) begin errors++; $display("FAIL flush_after got rx=%0d tx=%0d exp 6/1", rx[0], tx[0]); end
  endtask

  task automatic test_mid_reset;
    do_reset;
    for (int i = 0; i < 8; i++) begin sv = 1; sd = 8'(8'h40 + i); step; end
    srd = 1; step; step;
    checks++; if (lvl0 !== 5'd8 || tx[0] !== 32'd2 || rx[0] !== 32'd10) begin errors++; $display("FAIL mid_pre got lvl=%0d rx=%0d tx=%0d exp 8/10/2", lvl0, rx[0], tx[0]); end
    rst = 1; #1;
    checks++; if (rdy[0] !== 1'b0 || vld[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_hs got r=%b v=%b exp 0/0", rdy[0], vld[0]); end
    step;
    rst = 0; sv = 0; #1;
    checks++; if (lvl0 !== 5'd0 || rx[0] !== 32'd0 || tx[0] !== 32'd0) begin errors++; $display("FAIL mid_rst_state got lvl=%0d rx=%0d tx=%0d exp 0/0/0", lvl0, rx[0], tx[0]); end
    checks++; if (vld[0] !== 1'b0 || rdy[0] !== 1'b1) begin errors++; $display("FAIL mid_rst_release got v=%b r=%b exp 0/1", vld[0], rdy[0]); end
    step;
    checks++; if (tx[0] !== 32'd0) begin errors++; $display("FAIL mid_rst_nopop got tx=%0d exp 0", tx[0]); end
  endtask

  task automatic test_back_to_back;
    do_reset;
    srd = 1;
    for (int i = 0; i < 40; i++) begin
      sv = 1; sd = 8'(i * 7 + 3);
      step;
      checks++; if (vld[3] !== 1'b1 || dat[3] !== 8'(i * 7 + 3)) begin errors++; $display("FAIL wrap_data[%0d] got v=%b d=%h exp 1/%h", i, vld[3], dat[3], 8'(i * 7 + 3)); end
      checks++; if (lvl3 !== 3'd1) begin errors++; $display("FAIL wrap_level[%0d] got %0d exp 1", i, lvl3); end
    end
    sv = 0; step;
    checks++; if (lvl3 !== 3'd0 || rx[3] !== 32'd40 || tx[3] !== 32'd40) begin errors++; $display("FAIL wrap_end got lvl=%0d rx=%0d tx=%0d exp 0/40/40", lvl3, rx[3], tx[3]); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_full;
    test_transform;
    test_flush;
    test_mid_reset;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial2tcp_loopback_fifo.md
SERIAL2TCP_LOOPBACK_FIFO -- requirements
Module: serial2tcp_loopback_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the stream data width in bits (legal range 1..64).
REQ-002 Parameter DEPTH, default 16, SHALL set the FIFO depth in words; it SHALL be a power of two, 2..1024.
REQ-003 Parameter MODE, default 0, SHALL select the data transform: 0 = pass-through, 1 = XOR with XOR_MASK, 2 = increment (data+1 mod 2^DATA_WIDTH).
REQ-004 Parameter XOR_MASK, default all-ones of DATA_WIDTH, SHALL be the mask used when MODE=1.
REQ-005 sys_clk  input  1  single clock; all logic on the rising edge.
REQ-006 sys_rst  input  1  reset, synchronous and active-high.
REQ-007 flush  input  1  synchronous FIFO clear, active-high.
REQ-008 serial2tcp_sink_valid  input  1  the upstream word is valid.
REQ-009 serial2tcp_sink_ready  output  1  the block accepts the sink word this cycle.
REQ-010 serial2tcp_sink_data  input  DATA_WIDTH  the upstream word.
REQ-011 serial2tcp_source_valid  output  1  the downstream word is valid.
REQ-012 serial2tcp_source_ready  input  1  downstream accepts the word.
REQ-013 serial2tcp_source_data  output  DATA_WIDTH  the transformed word.
REQ-014 level  output  clog2(DEPTH)+1  the current FIFO occupancy in words.
REQ-015 rx_count, tx_count  output  32 each  accepted sink words and accepted source words.

Function
REQ-016 A sink transfer SHALL occur when sink_valid and sink_ready are both high on a rising edge; a source transfer SHALL occur when source_valid and source_ready are both high.
REQ-017 sink_ready SHALL equal (level != DEPTH) and not flush and not sys_rst; it is combinational from registered state only, with no dependence on sink_valid.
REQ-018 source_valid SHALL equal (level != 0); source_data SHALL be the transformed head word, stable while valid is high and ready is low.
REQ-019 The transform SHALL be applied on write; the FIFO stores transformed words.
REQ-020 Latency: a word accepted at edge N SHALL be presented on source at the cycle following edge N (1 cycle); there is no combinational sink-to-source bypass.
REQ-021 Full with a simultaneous pop: sink_ready SHALL stay low that cycle (no write-through), and level SHALL decrement by 1.
REQ-022 Empty: no pop is possible; a push SHALL raise level to 1 at the next edge.
REQ-023 A simultaneous push and pop SHALL leave level unchanged.
REQ-024 Read and write pointers SHALL be clog2(DEPTH) bits wide and wrap modulo DEPTH; level SHALL be a separate counter in the range 0..DEPTH.
REQ-025 flush high at an edge SHALL set the pointers and level to 0 and discard any source word at that edge, so that edge counts as neither a push nor a pop; rx_count and tx_count SHALL be unaffected.
REQ-026 rx_count SHALL increment on each sink transfer and tx_count on each source transfer; both SHALL wrap from 2^32-1 to 0.
REQ-027 Arithmetic SHALL be truncated to DATA_WIDTH; with MODE=2, an all-ones input SHALL produce 0.

Reset
REQ-028 sys_rst at an edge SHALL clear the pointers, level, rx_count and tx_count to 0; sink_ready and source_valid SHALL be 0 while sys_rst is high.
REQ-029 After sys_rst falls, sink_ready SHALL be 1 in the first cycle and source_valid SHALL be 0.
REQ-030 A reset asserted mid-stream SHALL discard all buffered words; FIFO memory contents need no reset.
REQ-031 sys_rst SHALL take priority over flush and over all transfers.

Verification
REQ-032 MODE=0, DEPTH=16: push 0x00..0x0F with source_ready=1 -> source emits 0x00..0x0F in order, each one cycle after acceptance; rx_count=tx_count=16.
REQ-033 MODE=0, DEPTH=16, source_ready=0: push 17 words -> sink_ready low after the 16th, level=16; then a single pop with sink_valid high -> no write that cycle and level=15.
REQ-034 MODE=1, XOR_MASK=0xFF: push 0x5A, 0x00 -> source emits 0xA5, 0xFF; MODE=2: push 0xFF, 0x7F -> source emits 0x00, 0x80.
REQ-035 Push 5 words, pulse flush with sink_valid high -> level=0, source_valid=0, rx_count=5; next push of 0x33 -> source emits 0x33.
REQ-036 Assert sys_rst with level=8 mid-stream -> level, rx_count and tx_count are 0; source_valid=0 in the cycle after reset releases.
REQ-037 Run 40 continuous push/pop transfers at DEPTH=4 -> pointers wrap with no loss or reorder, and level stays at 1 in steady state.
